// File: rtl/vm_pkg.sv
// vm_pkg: shared coin and sequencer types for the vending machine
package vm_pkg;

  typedef enum logic [1:0] {
    SLUG     = 2'b00,
    FARTHING = 2'b01,
    HAPENNY  = 2'b10,
    PENNY    = 2'b11
  } coin_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } vseq_state_t;

  function automatic logic [2:0] coin_value(coin_t c);
    return c == PENNY ? 3'd4 : c == HAPENNY ? 3'd2 : c == FARTHING ? 3'd1 : 3'd0;
  endfunction

endpackage

// File: rtl/change_selector.sv
// change_selector: greedy largest-coin choice for paying out a credit
import vm_pkg::*;

module change_selector #(
  parameter int CW = 5
) (
  input  logic [CW-1:0] credit,
  output coin_t         coin
);

  // Largest coin not exceeding the credit; a zero credit never reaches the payout
  always_comb coin = credit >= CW'(4) ? PENNY : credit >= CW'(2) ? HAPENNY : FARTHING;

endmodule

// File: rtl/vend_sequencer.sv
// vend_sequencer: coin credit accumulation, vend handshake and change payout
import vm_pkg::*;

module vend_sequencer #(
  parameter int PRICE = 12,
  parameter int CW    = 5
) (
  input  logic          clk50m,
  input  logic          res,
  input  logic          coin_valid,
  input  logic [1:0]    coin_type,
  output logic          coin_ready,
  input  logic          cancel,
  output logic          vend_valid,
  input  logic          vend_ready,
  output logic          change_valid,
  output logic [1:0]    change_coin,
  input  logic          change_ready,
  output logic [CW-1:0] credit,
  output logic [7:0]    vend_count,
  output logic          slug
);

  vseq_state_t   state;
  logic          accept;
  logic          vend_hs;
  logic          chg_hs;
  logic [CW-1:0] credit_nxt;
  coin_t         sel;

  change_selector #(.CW(CW)) u_sel (
    .credit(credit_nxt),
    .coin  (sel)
  );

  // Coins are only taken in IDLE and cancel always blocks them
  assign coin_ready = state == IDLE && !cancel;

  // Credit after this cycle's accepted coin, vend or change handshake
  always_comb begin
    accept     = coin_valid && coin_ready;
    vend_hs    = state == VEND && vend_ready;
    chg_hs     = state == CHANGE && change_ready;
    credit_nxt = accept  ? credit + CW'(coin_value(coin_t'(coin_type))) :
                 vend_hs ? credit - CW'(PRICE) :
                 chg_hs  ? credit - CW'(coin_value(coin_t'(change_coin))) : credit;
  end

  // Transaction FSM; change_coin is chosen from the post-handshake credit so it holds while stalled
  always_ff @(posedge clk50m or posedge res) begin
    if (res) begin
      state        <= IDLE;
      credit       <= '0;
      vend_count   <= '0;
      vend_valid   <= 1'b0;
      change_valid <= 1'b0;
      change_coin  <= SLUG;
      slug         <= 1'b0;
    end else begin
      credit <= credit_nxt;
      slug   <= accept && coin_type == SLUG;
      case (state)
        IDLE:
          if (cancel && credit != '0) begin
            state        <= CHANGE;
            change_valid <= 1'b1;
            change_coin  <= sel;
          end else if (credit_nxt >= CW'(PRICE)) begin
            state      <= VEND;
            vend_valid <= 1'b1;
          end
        VEND:
          if (vend_ready) begin
            vend_count <= vend_count + 8'd1;
            vend_valid <= 1'b0;
            if (credit_nxt != '0) begin
              state        <= CHANGE;
              change_valid <= 1'b1;
              change_coin  <= sel;
            end else
              state <= IDLE;
          end
        CHANGE:
          if (change_ready) begin
            if (credit_nxt == '0) begin
              state        <= IDLE;
              change_valid <= 1'b0;
              change_coin  <= SLUG;
            end else
              change_coin <= sel;
          end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer: directed checks of coin, vend, change, cancel and reset behaviour
module tb_vend_sequencer;

  logic       clk50m = 1'b0;
  logic       res = 1'b1;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_type = 2'b00;
  logic       coin_ready;
  logic       cancel = 1'b0;
  logic       vend_valid;
  logic       vend_ready = 1'b0;
  logic       change_valid;
  logic [1:0] change_coin;
  logic       change_ready = 1'b0;
  logic [4:0] credit;
  logic [7:0] vend_count;
  logic       slug;
  int         n_chk = 0;
  int         n_err = 0;

  vend_sequencer #(.PRICE(12), .CW(5)) dut (
    .clk50m      (clk50m),
    .res         (res),
    .coin_valid  (coin_valid),
    .coin_type   (coin_type),
    .coin_ready  (coin_ready),
    .cancel      (cancel),
    .vend_valid  (vend_valid),
    .vend_ready  (vend_ready),
    .change_valid(change_valid),
    .change_coin (change_coin),
    .change_ready(change_ready),
    .credit      (credit),
    .vend_count  (vend_count),
    .slug        (slug)
  );

  always #10 clk50m = ~clk50m;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk50m);
    #1;
  endtask

  task automatic put(input logic [1:0] c);
    coin_valid = 1'b1;
    coin_type  = c;
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic idle_zero(input string tag);
    chk({tag, " credit"}, credit, 0);
    chk({tag, " vend_count"}, vend_count, 0);
    chk({tag, " vend_valid"}, vend_valid, 0);
    chk({tag, " change_valid"}, change_valid, 0);
    chk({tag, " change_coin"}, change_coin, 0);
    chk({tag, " slug"}, slug, 0);
  endtask

  initial begin
    tick();
    tick();
    idle_zero("reset");
    res = 1'b0;
    chk("reset coin_ready", coin_ready, 1);

    vend_ready = 1'b1;
    put(2'b11);
    put(2'b11);
    chk("3p credit8", credit, 8);
    chk("3p no vend yet", vend_valid, 0);
    put(2'b11);
    chk("3p vend_valid", vend_valid, 1);
    chk("3p credit12", credit, 12);
    chk("3p coin_ready in VEND", coin_ready, 0);
    tick();
    chk("3p vend_valid drop", vend_valid, 0);
    chk("3p credit0", credit, 0);
    chk("3p vend_count", vend_count, 1);
    chk("3p no change", change_valid, 0);

    change_ready = 1'b1;
    put(2'b11);
    put(2'b11);
    put(2'b10);
    chk("14 credit10", credit, 10);
    put(2'b11);
    chk("14 vend_valid", vend_valid, 1);
    chk("14 credit14", credit, 14);
    tick();
    chk("14 vend_count", vend_count, 2);
    chk("14 credit2", credit, 2);
    chk("14 change_valid", change_valid, 1);
    chk("14 change_coin", change_coin, 2);
    chk("14 exclusive", vend_valid, 0);
    tick();
    chk("14 credit0", credit, 0);
    chk("14 change done", change_valid, 0);
    chk("14 idle coin_ready", coin_ready, 1);

    put(2'b11);
    put(2'b10);
    put(2'b01);
    chk("7 credit", credit, 7);
    cancel = 1'b1;
    #1;
    chk("7 cancel blocks coin", coin_ready, 0);
    tick();
    cancel = 1'b0;
    chk("7 chg1 valid", change_valid, 1);
    chk("7 chg1 coin", change_coin, 3);
    chk("7 chg1 credit", credit, 7);
    tick();
    chk("7 chg2 coin", change_coin, 2);
    chk("7 chg2 credit", credit, 3);
    tick();
    chk("7 chg3 coin", change_coin, 1);
    chk("7 chg3 credit", credit, 1);
    tick();
    chk("7 done valid", change_valid, 0);
    chk("7 done credit", credit, 0);
    chk("7 vend_count", vend_count, 2);

    change_ready = 1'b0;
    put(2'b11);
    put(2'b11);
    put(2'b10);
    put(2'b11);
    tick();
    chk("stall vend_count", vend_count, 3);
    for (int i = 0; i < 3; i++) begin
      coin_valid = 1'b1;
      coin_type  = 2'b11;
      #1;
      chk("stall coin_ready", coin_ready, 0);
      chk("stall change_valid", change_valid, 1);
      chk("stall change_coin", change_coin, 2);
      chk("stall credit", credit, 2);
      tick();
    end
    coin_valid   = 1'b0;
    change_ready = 1'b1;
    tick();
    chk("stall release credit", credit, 0);
    chk("stall release valid", change_valid, 0);

    put(2'b11);
    chk("race credit4", credit, 4);
    cancel     = 1'b1;
    coin_valid = 1'b1;
    coin_type  = 2'b11;
    #1;
    chk("race coin_ready", coin_ready, 0);
    tick();
    cancel     = 1'b0;
    coin_valid = 1'b0;
    chk("race credit kept", credit, 4);
    chk("race refund valid", change_valid, 1);
    chk("race refund coin", change_coin, 3);
    tick();
    chk("race refund done", credit, 0);
    chk("race refund idle", change_valid, 0);
    put(2'b00);
    chk("slug pulse", slug, 1);
    chk("slug credit", credit, 0);
    tick();
    chk("slug pulse end", slug, 0);

    change_ready = 1'b0;
    put(2'b10);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("mid change valid", change_valid, 1);
    chk("mid change credit", credit, 2);
    #3;
    res = 1'b1;
    #1;
    idle_zero("async reset");
    tick();
    res = 1'b0;
    idle_zero("after reset");

    vend_ready = 1'b1;
    for (int i = 0; i < 255; i++) begin
      put(2'b11);
      put(2'b11);
      put(2'b11);
      tick();
    end
    chk("count 255", vend_count, 255);
    put(2'b11);
    put(2'b11);
    put(2'b11);
    tick();
    chk("count wrap", vend_count, 0);
    chk("wrap credit", credit, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_chk, n_err);
    $finish;
  end

endmodule
